// File: rtl/sram_pkg.sv
// ---------------------------------------------------------------------------
// sram_pkg
// Shared definitions for the data-memory SRAM controller.
//   state_t            : controller state encoding (IDLE/READ/WRITE/DONE)
//   SRAM_ADDR_W        : width of the external halfword address bus
//   SRAM_DATA_W        : width of the external data bus
//   BLOCK_W            : width of a cache fill block (two ARM words)
//   CNT_W              : width of the in-slot cycle counter
//   DEFAULT_ADDR_BASE  : byte address of the first data-memory location
// ---------------------------------------------------------------------------
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;
    localparam int BLOCK_W     = 64;

    // Enough to count up to the largest legal slot length (15 cycles).
    localparam int CNT_W = 4;

    localparam logic [31:0] DEFAULT_ADDR_BASE     = 32'd1024;
    localparam int          DEFAULT_ACCESS_CYCLES = 2;

endpackage

// File: rtl/sram_slot_counter.sv
// ---------------------------------------------------------------------------
// sram_slot_counter
// Counts clock cycles inside one SRAM access slot and the index of the slot
// within the current operation. Both counters sit at zero while disabled, so
// every operation starts in slot 0, cycle 0.
//   clk_i             : system clock
//   rst_ni            : asynchronous active-low reset
//   en_i              : high while an operation (READ/WRITE) is in progress
//   slot_last_o       : current cycle is the last cycle of the current slot
//   index_o           : current slot index (0..3)
//   last_after_step_o : the cycle following an enabled step will be the last
//                       cycle of its slot (lookahead for registered strobes)
// ---------------------------------------------------------------------------
module sram_slot_counter
    import sram_pkg::*;
#(
    parameter int ACCESS_CYCLES = DEFAULT_ACCESS_CYCLES
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    output logic       slot_last_o,
    output logic [1:0] index_o,
    output logic       last_after_step_o
);

    localparam logic [CNT_W-1:0] LAST_CNT      = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic             FIRST_IS_LAST = (ACCESS_CYCLES == 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       index_q, index_d;

    assign slot_last_o = (cnt_q == LAST_CNT);
    assign index_o     = index_q;

    // A step out of the last cycle starts a new slot at cycle 0, which is
    // itself the last cycle only for single-cycle slots.
    assign last_after_step_o = slot_last_o ? FIRST_IS_LAST
                                           : ((cnt_q + 1'b1) == LAST_CNT);

    always_comb begin
        cnt_d   = cnt_q;
        index_d = index_q;
        if (!en_i) begin
            cnt_d   = '0;
            index_d = '0;
        end else if (slot_last_o) begin
            cnt_d   = '0;
            index_d = index_q + 2'd1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            index_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            index_q <= index_d;
        end
    end

endmodule

// File: rtl/sram_controller.sv
// ---------------------------------------------------------------------------
// sram_controller
// Bridges the data cache controller to a 16-bit asynchronous SRAM. A word
// write becomes two halfword writes; a block read becomes four halfword reads
// assembled into a 64-bit cache fill block. One ready pulse per request.
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   address    : byte address from the cache controller
//   wdata      : word to write
//   sram_read  : block-read request, held until ready
//   sram_write : word-write request, held until ready (wins over read)
//   rdata      : last block read, bits [15:0] = lowest halfword
//   ready      : one-cycle completion pulse
//   SRAM_DQ    : bidirectional SRAM data bus
//   SRAM_ADDR  : SRAM halfword address
//   SRAM_WE_N / SRAM_OE_N / SRAM_CE_N : active-low SRAM strobes
//   SRAM_UB_N / SRAM_LB_N             : byte enables, always both bytes
// ---------------------------------------------------------------------------
module sram_controller
    import sram_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE     = DEFAULT_ADDR_BASE,
    parameter int          ACCESS_CYCLES = DEFAULT_ACCESS_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            address,
    input  logic [31:0]            wdata,
    input  logic                   sram_read,
    input  logic                   sram_write,
    output logic [BLOCK_W-1:0]     rdata,
    output logic                   ready,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N
);

    localparam logic FIRST_IS_LAST = (ACCESS_CYCLES == 1);

    state_t                 state_q;
    logic [18:2]            off_q;
    logic [31:0]            off_d;
    logic [15:0]            wdata_hi_q;
    logic [SRAM_DATA_W-1:0] dq_q;
    logic                   dq_oe_q;
    logic [SRAM_ADDR_W-1:0] sram_addr_q;
    logic                   we_n_q, oe_n_q, ce_n_q;
    logic                   ready_q;
    logic [BLOCK_W-1:0]     rdata_q;

    logic                   slot_last;
    logic [1:0]             index;
    logic                   last_after_step;
    logic                   cnt_en;

    // Only bits [18:2] of the offset matter: the low two select a byte inside
    // a word and everything above 18 falls outside the SRAM.
    assign off_d = address - ADDR_BASE;
    wire unused_off_bits = ^{off_d[31:19], off_d[1:0]};

    assign cnt_en = (state_q == READ) || (state_q == WRITE);

    sram_slot_counter #(
        .ACCESS_CYCLES(ACCESS_CYCLES)
    ) u_slot_counter (
        .clk_i            (clk),
        .rst_ni           (rst),
        .en_i             (cnt_en),
        .slot_last_o      (slot_last),
        .index_o          (index),
        .last_after_step_o(last_after_step)
    );

    assign SRAM_DQ   = dq_oe_q ? dq_q : {SRAM_DATA_W{1'bz}};
    assign SRAM_ADDR = sram_addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_CE_N = ce_n_q;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign rdata     = rdata_q;
    assign ready     = ready_q;

    // Controller FSM. All SRAM-facing outputs are registered and computed one
    // cycle ahead, so the address moves on the same edge as the slot boundary
    // and WE_N rises one cycle before the address/data change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            off_q       <= '0;
            wdata_hi_q  <= '0;
            dq_q        <= '0;
            dq_oe_q     <= 1'b0;
            sram_addr_q <= '0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            ce_n_q      <= 1'b1;
            ready_q     <= 1'b0;
            rdata_q     <= '0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sram_write) begin
                        state_q     <= WRITE;
                        off_q       <= off_d[18:2];
                        wdata_hi_q  <= wdata[31:16];
                        dq_q        <= wdata[15:0];
                        dq_oe_q     <= 1'b1;
                        sram_addr_q <= {off_d[18:2], 1'b0};
                        ce_n_q      <= 1'b0;
                        oe_n_q      <= 1'b1;
                        we_n_q      <= 1'b0;
                    end else if (sram_read) begin
                        state_q     <= READ;
                        off_q       <= off_d[18:2];
                        sram_addr_q <= {off_d[18:3], 2'b00};
                        ce_n_q      <= 1'b0;
                        oe_n_q      <= 1'b0;
                        we_n_q      <= 1'b1;
                    end
                end

                READ: begin
                    if (slot_last) begin
                        rdata_q[{index, 4'b0000} +: SRAM_DATA_W] <= SRAM_DQ;
                        if (index == 2'd3) begin
                            state_q <= DONE;
                            ce_n_q  <= 1'b1;
                            oe_n_q  <= 1'b1;
                            ready_q <= 1'b1;
                        end else begin
                            sram_addr_q <= {off_q[18:3], index + 2'd1};
                        end
                    end
                end

                WRITE: begin
                    if (slot_last && index[0]) begin
                        state_q <= DONE;
                        ce_n_q  <= 1'b1;
                        we_n_q  <= 1'b1;
                        dq_oe_q <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        if (slot_last) begin
                            sram_addr_q <= {off_q[18:2], 1'b1};
                            dq_q        <= wdata_hi_q;
                        end
                        // Single-cycle slots keep WE_N low throughout.
                        we_n_q <= last_after_step && !FIRST_IS_LAST;
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The data bus may only be driven while a write is in progress.
    assert property (@(posedge clk) disable iff (!rst) dq_oe_q |-> (state_q == WRITE));

endmodule

// File: tb/tb_sram_controller.sv
// ---------------------------------------------------------------------------
// tb_sram_controller
// Three controllers (ACCESS_CYCLES = 2, 1, 4), each with its own behavioural
// asynchronous SRAM. Directed read/write/reset sequences with hand-computed
// expectations.
// ---------------------------------------------------------------------------
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [2:0]  rdReq, wrReq;
    logic [2:0]  readyV, weN, oeN, ceN, ubN, lbN;
    logic [63:0] rdataV [3];
    logic [17:0] sAddr [3];
    wire  [15:0] dq0, dq1, dq2;

    logic [15:0] mem [3][256];
    logic        loadMem;

    int          acTab [3] = '{2, 1, 4};
    logic [17:0] addrLog [0:127];
    logic        weLog [0:127];
    int          testsRun = 0;
    int          testsFailed = 0;
    int          rc;

    // Free-running system clock.
    always #5 clk = ~clk;

    sram_controller #(.ACCESS_CYCLES(2)) u_dut0 (
        .clk(clk), .rst(rst), .address(address), .wdata(wdata),
        .sram_read(rdReq[0]), .sram_write(wrReq[0]), .rdata(rdataV[0]), .ready(readyV[0]),
        .SRAM_DQ(dq0), .SRAM_ADDR(sAddr[0]), .SRAM_WE_N(weN[0]), .SRAM_OE_N(oeN[0]),
        .SRAM_CE_N(ceN[0]), .SRAM_UB_N(ubN[0]), .SRAM_LB_N(lbN[0])
    );

    sram_controller #(.ACCESS_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .address(address), .wdata(wdata),
        .sram_read(rdReq[1]), .sram_write(wrReq[1]), .rdata(rdataV[1]), .ready(readyV[1]),
        .SRAM_DQ(dq1), .SRAM_ADDR(sAddr[1]), .SRAM_WE_N(weN[1]), .SRAM_OE_N(oeN[1]),
        .SRAM_CE_N(ceN[1]), .SRAM_UB_N(ubN[1]), .SRAM_LB_N(lbN[1])
    );

    sram_controller #(.ACCESS_CYCLES(4)) u_dut2 (
        .clk(clk), .rst(rst), .address(address), .wdata(wdata),
        .sram_read(rdReq[2]), .sram_write(wrReq[2]), .rdata(rdataV[2]), .ready(readyV[2]),
        .SRAM_DQ(dq2), .SRAM_ADDR(sAddr[2]), .SRAM_WE_N(weN[2]), .SRAM_OE_N(oeN[2]),
        .SRAM_CE_N(ceN[2]), .SRAM_UB_N(ubN[2]), .SRAM_LB_N(lbN[2])
    );

    // Asynchronous SRAM read path: drives the bus while selected for reading.
    assign dq0 = (!ceN[0] && !oeN[0] && weN[0]) ? mem[0][sAddr[0][7:0]] : 16'hzzzz;
    assign dq1 = (!ceN[1] && !oeN[1] && weN[1]) ? mem[1][sAddr[1][7:0]] : 16'hzzzz;
    assign dq2 = (!ceN[2] && !oeN[2] && weN[2]) ? mem[2][sAddr[2][7:0]] : 16'hzzzz;

    // SRAM write path (sampled mid-cycle while CE and WE are low) and the
    // initial preload: halfword i (i < 8) holds 0x1111 * (i + 1).
    always @(negedge clk) begin
        if (loadMem) begin
            for (int k = 0; k < 3; k++)
                for (int i = 0; i < 256; i++)
                    mem[k][i] <= (i < 8) ? {4{4'(i + 1)}} : 16'h0000;
        end else begin
            if (!ceN[0] && !weN[0]) mem[0][sAddr[0][7:0]] <= dq0;
            if (!ceN[1] && !weN[1]) mem[1][sAddr[1][7:0]] <= dq1;
            if (!ceN[2] && !weN[2]) mem[2][sAddr[2][7:0]] <= dq2;
        end
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Issues one request to controller k from an IDLE cycle and waits for
    // ready. readyCycle counts cycles from the sampling edge; addrLog/weLog
    // record the bus seen in each of those cycles.
    task automatic applyStimulus(input int k, input bit isWrite, input bit alsoRead,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 output int readyCycle);
        @(negedge clk);
        address  = addr;
        wdata    = wd;
        rdReq[k] = !isWrite || alsoRead;
        wrReq[k] = isWrite;
        @(posedge clk);
        readyCycle = -1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (n == 1) begin
                address = 32'hFFFF_FFFF;
                wdata   = 32'h0000_0000;
            end
            addrLog[n] = sAddr[k];
            weLog[n]   = weN[k];
            if (readyV[k]) begin
                readyCycle = n;
                break;
            end
        end
        rdReq[k] = 1'b0;
        wrReq[k] = 1'b0;
        if (readyCycle < 0) checkOutput("readyTimeout", 64'd0, 64'd1);
    endtask

    // Hard stop in case anything ever stalls the sequence below.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        address = '0;
        wdata   = '0;
        rdReq   = '0;
        wrReq   = '0;
        loadMem = 1'b1;
        rst     = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rstReady", 64'(readyV[0]), 64'd0);
        checkOutput("rstRdata", rdataV[0], 64'd0);
        checkOutput("rstStrobes", 64'({ceN[0], oeN[0], weN[0]}), 64'b111);
        checkOutput("rstAddr", 64'(sAddr[0]), 64'd0);
        checkOutput("rstUbLb", 64'({ubN[0], lbN[0]}), 64'b00);
        loadMem = 1'b0;
        rst     = 1'b1;

        // Aligned block read at the base address.
        applyStimulus(0, 1'b0, 1'b0, 32'd1024, 32'd0, rc);
        checkOutput("rdLatency", 64'(rc), 64'd9);
        checkOutput("rdData", rdataV[0], 64'h4444_3333_2222_1111);
        for (int n = 1; n <= 8; n++)
            checkOutput("rdAddrSeq", 64'(addrLog[n]), 64'((n - 1) / 2));
        checkOutput("rdWeHigh", 64'(weLog[3]), 64'd1);

        // Word offset 3: same block as halfwords 4..7, low address bits ignored.
        applyStimulus(0, 1'b0, 1'b0, 32'd1036, 32'd0, rc);
        checkOutput("rdUnalLatency", 64'(rc), 64'd9);
        checkOutput("rdUnalData", rdataV[0], 64'h8888_7777_6666_5555);
        checkOutput("rdUnalFirst", 64'(addrLog[1]), 64'd4);
        checkOutput("rdUnalLast", 64'(addrLog[8]), 64'd7);

        // Word write to halfwords 2/3.
        applyStimulus(0, 1'b1, 1'b0, 32'd1028, 32'hDEAD_BEEF, rc);
        checkOutput("wrLatency", 64'(rc), 64'd5);
        checkOutput("wrWeSlot0a", 64'(weLog[1]), 64'd0);
        checkOutput("wrWeSlot0b", 64'(weLog[2]), 64'd1);
        checkOutput("wrWeSlot1a", 64'(weLog[3]), 64'd0);
        checkOutput("wrWeSlot1b", 64'(weLog[4]), 64'd1);
        checkOutput("wrAddr0", 64'(addrLog[2]), 64'd2);
        checkOutput("wrAddr1", 64'(addrLog[3]), 64'd3);
        checkOutput("wrMemLo", 64'(mem[0][2]), 64'h0000_BEEF);
        checkOutput("wrMemHi", 64'(mem[0][3]), 64'h0000_DEAD);
        checkOutput("wrRdataHeld", rdataV[0], 64'h8888_7777_6666_5555);

        // Both requests high: the write wins (halfwords 8/9).
        applyStimulus(0, 1'b1, 1'b1, 32'd1040, 32'h1234_5678, rc);
        checkOutput("bothLatency", 64'(rc), 64'd5);
        checkOutput("bothMemLo", 64'(mem[0][8]), 64'h0000_5678);
        checkOutput("bothMemHi", 64'(mem[0][9]), 64'h0000_1234);
        checkOutput("bothRdataHeld", rdataV[0], 64'h8888_7777_6666_5555);

        // Read straight after, one IDLE cycle between: sees the earlier write.
        applyStimulus(0, 1'b0, 1'b0, 32'd1024, 32'd0, rc);
        checkOutput("rdAfterWrLatency", 64'(rc), 64'd9);
        checkOutput("rdAfterWrData", rdataV[0], 64'hDEAD_BEEF_2222_1111);

        // Reset during slot 2 of a read aborts it and clears rdata.
        @(negedge clk);
        address  = 32'd1024;
        rdReq[0] = 1'b1;
        @(posedge clk);
        repeat (5) @(negedge clk);
        checkOutput("midRdAddr", 64'(sAddr[0]), 64'd2);
        rst = 1'b0;
        #1;
        checkOutput("abortStrobes", 64'({ceN[0], oeN[0], weN[0]}), 64'b111);
        checkOutput("abortRdata", rdataV[0], 64'd0);
        checkOutput("abortReady", 64'(readyV[0]), 64'd0);
        checkOutput("abortAddr", 64'(sAddr[0]), 64'd0);
        rdReq[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        applyStimulus(0, 1'b0, 1'b0, 32'd1024, 32'd0, rc);
        checkOutput("postRstLatency", 64'(rc), 64'd9);
        checkOutput("postRstData", rdataV[0], 64'hDEAD_BEEF_2222_1111);

        // Slot-length sweep on the ACCESS_CYCLES = 1 and 4 controllers.
        for (int k = 1; k < 3; k++) begin
            applyStimulus(k, 1'b0, 1'b0, 32'd1024, 32'd0, rc);
            checkOutput("sweepRdLatency", 64'(rc), 64'(4 * acTab[k] + 1));
            checkOutput("sweepRdData", rdataV[k], 64'h4444_3333_2222_1111);
            applyStimulus(k, 1'b1, 1'b0, 32'd1028, 32'hDEAD_BEEF, rc);
            checkOutput("sweepWrLatency", 64'(rc), 64'(2 * acTab[k] + 1));
            checkOutput("sweepWeFirst", 64'(weLog[1]), 64'd0);
            checkOutput("sweepWeSlot0End", 64'(weLog[acTab[k]]), (acTab[k] == 1) ? 64'd0 : 64'd1);
            checkOutput("sweepWeSlot1End", 64'(weLog[2 * acTab[k]]), (acTab[k] == 1) ? 64'd0 : 64'd1);
            checkOutput("sweepMemLo", 64'(mem[k][2]), 64'h0000_BEEF);
            checkOutput("sweepMemHi", 64'(mem[k][3]), 64'h0000_DEAD);
            checkOutput("sweepRdataHeld", rdataV[k], 64'h4444_3333_2222_1111);
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Sits directly downstream of the data cache controller in the MEM stage.
- Turns the cache's single-word write requests and 64-bit block-read requests into sequences of 16-bit accesses on the external asynchronous SRAM (18-bit halfword address, 16-bit DQ).
- Returns one `ready` pulse per request.
- Read data is a 64-bit block holding two adjacent ARM words, ready for direct fill into a cache way.

Parameters:
- ADDR_BASE, 1024: byte address of the first data-memory location. It is subtracted from `address` before mapping.
- ACCESS_CYCLES, 2: clock cycles per 16-bit SRAM access slot. Legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- address  in  32  byte address from the cache controller.
- wdata  in  32  word to write.
- sram_read  in  1  block-read request, held until ready.
- sram_write  in  1  word-write request, held until ready.
- rdata  out  64  read block; bits [15:0] = lowest halfword.
- ready  out  1  one-cycle completion pulse.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  out  18  SRAM halfword address.
- SRAM_WE_N  out  1  write enable, active low.
- SRAM_OE_N  out  1  output enable, active low.
- SRAM_CE_N  out  1  chip enable, active low.
- SRAM_UB_N  out  1  upper byte enable; tied 0.
- SRAM_LB_N  out  1  lower byte enable; tied 0.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, slot counter=0, halfword index=0.
  - rdata=0, ready=0, SRAM_ADDR=0.
  - SRAM_WE_N=1, SRAM_OE_N=1, SRAM_CE_N=1, SRAM_DQ=Z.
  - Reset mid-operation aborts the access immediately. No ready pulse; rdata is cleared.
- Address mapping:
  - off = (address - ADDR_BASE), modulo 2^32.
  - Read slot i (i=0..3): SRAM_ADDR = {off[18:3], i[1:0]}.
  - Write slot j (j=0..1): SRAM_ADDR = {off[18:2], j[0]}.
  - address[2:0] do not affect block alignment. Bits above 18 are ignored.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - Requests are sampled only here.
  - sram_write=1 -> WRITE. Write has priority if both requests are high.
  - Else sram_read=1 -> READ.
  - Else stay in IDLE.
  - The address is registered on the transition and held for the whole operation. Later changes to address, wdata or the requests are ignored until IDLE is re-entered.
- READ:
  - CE_N=0, OE_N=0, WE_N=1, DQ=Z.
  - Each slot lasts ACCESS_CYCLES cycles.
  - On the last cycle of slot i, SRAM_DQ is captured into rdata[16i+15:16i].
  - After slot 3 -> DONE.
- WRITE:
  - CE_N=0, OE_N=1.
  - DQ is driven with wdata[15:0] in slot 0 and wdata[31:16] in slot 1.
  - WE_N=0 in every cycle of a slot except the last. For ACCESS_CYCLES=1 it is low for the whole slot. Address and data stay stable while WE_N rises.
  - After slot 1 -> DONE.
- DONE:
  - ready=1 for exactly this cycle. CE_N=1, DQ=Z.
  - Unconditionally -> IDLE.
  - The cache drops its request on the same edge, so IDLE never sees a stale request.
- Latency, counted from the edge that samples the request:
  - Read: ready is high during cycle 4·ACCESS_CYCLES+1 (9 cycles at default).
  - Write: ready is high during cycle 2·ACCESS_CYCLES+1 (5 cycles at default).
- rdata is updated only by reads, so it holds across writes and idle periods.
- SRAM_DQ is driven only in the WRITE state. It is never driven in the cycle the state leaves WRITE.
- No back-to-back requests: at least one IDLE cycle always separates DONE from the next READ/WRITE.

Decomposition:
- Shared package (e.g. sram_pkg):
  - state encoding constants IDLE/READ/WRITE/DONE (2 bits);
  - SRAM_ADDR_W=18, SRAM_DATA_W=16, BLOCK_W=64;
  - default ADDR_BASE.
- One natural sub-module, sram_slot_counter. It counts cycles within a slot and the slot index, and outputs `slot_last` and `index`.
- The FSM, address mux and DQ tristate stay in sram_controller.

Test Plan:
- Reset mid-read: assert rst=0 in slot 2 -> all SRAM strobes high, DQ=Z, rdata=0, no ready pulse; next request runs normally.
- Read: SRAM model preloaded at halfwords 0..3 with 0x1111, 0x2222, 0x3333, 0x4444; sram_read with address=1024 -> SRAM_ADDR 0, 1, 2, 3, two cycles each; ready in cycle 9; rdata=0x4444_3333_2222_1111.
- Read, unaligned within block: address=1036 (word offset 3) -> SRAM_ADDR 4..7 read; full block returned; address bits [2:0] ignored.
- Write: wdata=0xDEAD_BEEF, address=1028 -> halfword 2 gets 0xBEEF and halfword 3 gets 0xDEAD; WE_N low only in the first cycle of each slot; ready in cycle 5; rdata unchanged.
- Simultaneous sram_read=1 and sram_write=1 -> write sequence only. Then drop both for one cycle and raise sram_read -> read starts after one IDLE cycle.
- Parameter sweep ACCESS_CYCLES=1 and 4 -> read ready in cycles 5 and 17, write ready in cycles 3 and 9; DQ never driven outside WRITE (checked by assertion).
